// File: rtl/magic_pipe.sv
// magic_pipe: STAGES-deep mixing pipeline. Each stage applies XOR, rotate-left,
// add or invert to the word, selected by a 2-bit key slice of the original
// input word. Valid/ready flow control with bubble collapse and full backpressure.
// Optional feature macro: MAGIC_PIPE_MATCH_EN adds the match output, the EXPECT
// parameter and a sticky match_seen probe.
module magic_pipe #(
   parameter int unsigned      WIDTH  = 8,
   parameter int unsigned      STAGES = 4,
   parameter logic [WIDTH-1:0] SALT   = WIDTH'(8'h5A)
`ifdef MAGIC_PIPE_MATCH_EN
   ,
   parameter logic [WIDTH-1:0] EXPECT = '0
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef MAGIC_PIPE_MATCH_EN
   ,
   output logic             match
`endif
);

   // The key word is only needed by downstream stages, so the last stage keeps none.
   localparam int unsigned KN = (STAGES > 1) ? STAGES - 1 : 1;

   logic [STAGES-1:0] v_q, v_d;
   logic [WIDTH-1:0]  d_q [STAGES];
   logic [WIDTH-1:0]  d_d [STAGES];
   logic [WIDTH-1:0]  k_q [KN];
   logic [WIDTH-1:0]  k_d [KN];
   logic [STAGES:0]   rdy;

   // Ready chain, per-stage operation select and next-state for every stage register.
   always_comb begin
      logic             r;
      logic             up_v [STAGES];
      logic [WIDTH-1:0] up_d [STAGES];
      logic [WIDTH-1:0] up_k [STAGES];
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] cs;
      logic [WIDTH-1:0] res;
      logic [1:0]       kv;

      rdy         = '0;
      rdy[STAGES] = out_ready;
      r           = out_ready;
      for (int unsigned i = 0; i < STAGES; i++) begin
         r                = ~v_q[STAGES-1-i] | r;
         rdy[STAGES-1-i]  = r;
      end

      up_v[0] = in_valid;
      up_d[0] = in_data;
      up_k[0] = in_data;
      for (int unsigned s = 1; s < STAGES; s++) begin
         up_v[s] = v_q[s-1];
         up_d[s] = d_q[s-1];
         up_k[s] = k_q[s-1];
      end

      v_d = v_q;
      for (int unsigned s = 0; s < STAGES; s++) begin
         x  = up_d[s];
         kv = up_k[s][(2*s) % WIDTH +: 2];
         cs = SALT + WIDTH'(s);
         case (kv)
            2'd0:    res = x ^ cs;
            2'd1:    res = {x[WIDTH-2:0], x[WIDTH-1]};
            2'd2:    res = x + cs;
            default: res = ~x;
         endcase
         v_d[s] = rdy[s] ? up_v[s] : v_q[s];
         d_d[s] = (rdy[s] & up_v[s]) ? res : d_q[s];
      end

      for (int unsigned s = 0; s < KN; s++) begin
         k_d[s] = (rdy[s] & up_v[s]) ? up_k[s] : k_q[s];
      end
   end

   // Stage registers; reset discards every word in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q <= '0;
         for (int unsigned s = 0; s < STAGES; s++) d_q[s] <= '0;
         for (int unsigned s = 0; s < KN; s++)     k_q[s] <= '0;
      end else begin
         v_q <= v_d;
         for (int unsigned s = 0; s < STAGES; s++) d_q[s] <= d_d[s];
         for (int unsigned s = 0; s < KN; s++)     k_q[s] <= k_d[s];
      end
   end

   // Handshake outputs; in_ready is forced low while reset is asserted.
   always_comb begin
      in_ready  = rdy[0] & rst;
      out_valid = v_q[STAGES-1];
      out_data  = d_q[STAGES-1];
   end

`ifdef MAGIC_PIPE_MATCH_EN
   logic sticky_q, sticky_d;
   logic match_seen;

   // Output compare and sticky record of any accepted matching word.
   always_comb begin
      match      = out_valid & (out_data == EXPECT);
      sticky_d   = sticky_q | (match & out_ready);
      match_seen = sticky_q | match;
   end

   // Sticky match bit, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sticky_q <= 1'b0;
      else      sticky_q <= sticky_d;
   end
`endif

endmodule

// File: tb/tb_magic_pipe.sv
// Testbench for magic_pipe (WIDTH=8, STAGES=4, SALT=8'h5A), table-driven vectors
// plus directed stream, stall and mid-flight reset sequences.
module tb_magic_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
`ifdef MAGIC_PIPE_MATCH_EN
   logic       match;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   magic_pipe #(
      .WIDTH (8),
      .STAGES(4),
      .SALT  (8'h5A)
`ifdef MAGIC_PIPE_MATCH_EN
      ,
      .EXPECT(8'h18)
`endif
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data)
`ifdef MAGIC_PIPE_MATCH_EN
      ,
      .match    (match)
`endif
   );

   typedef struct {
      logic [7:0] din;
      logic [7:0] dout;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Push one word into an idle pipe, then time and check its output.
   task automatic send_one(input string name, input logic [7:0] din, input logic [7:0] dout);
      int lat;
      bit got;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = din;
      @(negedge clk);
      chk({name, " in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 'x;
      lat = 0;
      got = 1'b0;
      for (int c = 1; c <= 20 && !got; c++) begin
         @(negedge clk);
         if (out_valid) begin
            got = 1'b1;
            lat = c;
         end
      end
      chk({name, " latency"}, 32'(lat), 32'd4);
      chk({name, " data"}, 32'(out_data), 32'(dout));
`ifdef MAGIC_PIPE_MATCH_EN
      chk({name, " match"}, 32'(match), 32'(dout == 8'h18));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] sw [6];
      logic [7:0] se [6];
      int wi, ri, occ, stale;
      bit acc, pop;

      vecs[0] = '{8'h00, 8'h00};
      vecs[1] = '{8'hFF, 8'hFF};
      vecs[2] = '{8'h55, 8'h55};
      vecs[3] = '{8'hAA, 8'h18};
      vecs[4] = '{8'h1B, 8'h23};
      vecs[5] = '{8'hE4, 8'h26};
      vecs[6] = '{8'h72, 8'hD0};

      sw = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h1B, 8'hE4};
      se = '{8'h00, 8'hFF, 8'h55, 8'h18, 8'h23, 8'h26};

      // Reset state
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_data", 32'(out_data), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd0);
`ifdef MAGIC_PIPE_MATCH_EN
      chk("reset match", 32'(match), 32'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("release in_ready", 32'(in_ready), 32'd1);

      // Single-word vectors
      for (int i = 0; i < 7; i++) begin
         send_one($sformatf("vec%0d", i), vecs[i].din, vecs[i].dout);
      end

      // Back-to-back stream, no backpressure: outputs on cycles 4..7
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         out_ready = 1'b1;
         if (c < 4) begin
            in_valid = 1'b1;
            in_data  = sw[c];
         end else begin
            in_valid = 1'b0;
            in_data  = 'x;
         end
         @(negedge clk);
         chk($sformatf("stream c%0d valid", c), 32'(out_valid), 32'(c >= 4 && c < 8));
         if (c >= 4 && c < 8) chk($sformatf("stream c%0d data", c), 32'(out_data), 32'(se[c-4]));
      end

      // Stall for 6 cycles from the first out_valid, with more words pending
      wi  = 0;
      ri  = 0;
      occ = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         out_ready = !(c >= 4 && c < 10);
         if (wi < 6) begin
            in_valid = 1'b1;
            in_data  = sw[wi];
         end else begin
            in_valid = 1'b0;
            in_data  = 'x;
         end
         @(negedge clk);
         chk($sformatf("stall c%0d in_ready", c), 32'(in_ready), 32'((occ < 4) || out_ready));
         if (c >= 4 && c < 10) chk($sformatf("stall c%0d hold valid", c), 32'(out_valid), 32'd1);
         if (out_valid) begin
            if (ri < 6) chk($sformatf("stall c%0d data", c), 32'(out_data), 32'(se[ri]));
            else        chk($sformatf("stall c%0d extra word", c), 32'(out_valid), 32'd0);
         end
         acc = in_valid && in_ready;
         pop = out_valid && out_ready;
         if (acc) wi++;
         if (pop) ri++;
         occ = occ + int'(acc) - int'(pop);
      end
      chk("stall all accepted", 32'(wi), 32'd6);
      chk("stall all delivered", 32'(ri), 32'd6);

      // Reset while three words are in flight and the head is stalled at the output
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_data  = (c == 0) ? 8'hFF : (c == 1) ? 8'hAA : 8'h55;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 'x;
      @(negedge clk);
      @(negedge clk);
      chk("pre-reset out_valid", 32'(out_valid), 32'd1);
      chk("pre-reset out_data", 32'(out_data), 32'hFF);
      #2;
      rst = 1'b0;
      #1;
      chk("mid reset out_valid", 32'(out_valid), 32'd0);
      chk("mid reset out_data", 32'(out_data), 32'd0);
      chk("mid reset in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      @(posedge clk); #1;
      rst       = 1'b1;
      out_ready = 1'b1;
      stale     = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      chk("no stale after reset", 32'(stale), 32'd0);
      send_one("post-reset AA", 8'hAA, 8'h18);
`ifdef MAGIC_PIPE_MATCH_EN
      @(posedge clk); #1;
      chk("match_seen sticky", 32'(dut.match_seen), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
